fetch_unit: RTL and testbench

Instruction-fetch front end for the pd5 pipeline and the consumer of the hazard controls `stall_if` and `e_br_taken`. It owns the PC and issues in-order requests to instruction memory. It buffers returned instructions and presents them to the IF/ID register. It holds presentation while stalled, and on a taken branch it redirects, flushing buffered and in-flight wrong-path instructions.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Request: a transfer happens on a rising edge where imem_req_valid && imem_req_ready; response: one imem_rsp_valid pulse per accepted request, in order.
interface fetch_unit_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              imem_req_valid;
  logic [AWIDTH-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DWIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order memory requests, buffers
// returned words and presents them to IF/ID, with stall hold and branch redirect/flush.
module fetch_unit #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = 32'h0100_0000,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              br_taken,
  input  logic [AWIDTH-1:0] br_target,
  fetch_unit_if.master      imem,
  output logic              f_valid,
  output logic [AWIDTH-1:0] f_pc,
  output logic [DWIDTH-1:0] f_insn
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] W_CAP = (CW + 1)'(QDEPTH);

  logic [AWIDTH-1:0] r_fetch_pc;

  logic [AWIDTH-1:0] r_if_pc [QDEPTH];
  logic [PW-1:0]     r_if_wp;
  logic [PW-1:0]     r_if_rp;
  logic [CW-1:0]     r_if_cnt;

  logic [AWIDTH-1:0] r_q_pc   [QDEPTH];
  logic [DWIDTH-1:0] r_q_insn [QDEPTH];
  logic [PW-1:0]     r_q_wp;
  logic [PW-1:0]     r_q_rp;
  logic [CW-1:0]     r_q_cnt;

  logic [CW-1:0]     r_drop_cnt;

  logic [CW:0]       w_used;
  logic              w_req_valid;
  logic              w_acc;
  logic              w_rsp;
  logic              w_keep;
  logic              w_pop;
  logic [CW-1:0]     w_if_cnt_nxt;

  // Credits count both in-flight and buffered entries, so the queue can never overflow.
  assign w_used      = {1'b0, r_if_cnt} + {1'b0, r_q_cnt};
  assign w_req_valid = (w_used < W_CAP);
  assign w_acc       = w_req_valid & imem.imem_req_ready;
  assign w_rsp       = imem.imem_rsp_valid & (r_if_cnt != '0);
  assign w_keep      = w_rsp & (r_drop_cnt == '0) & ~br_taken;
  assign w_pop       = (r_q_cnt != '0) & ~stall_if & ~br_taken;
  assign w_if_cnt_nxt = r_if_cnt + CW'(w_acc) - CW'(w_rsp);

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_fetch_pc;

  assign f_valid = (r_q_cnt != '0);
  assign f_pc    = r_q_pc[r_q_rp];
  assign f_insn  = r_q_insn[r_q_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_if_wp    <= '0;
      r_if_rp    <= '0;
      r_if_cnt   <= '0;
      r_q_wp     <= '0;
      r_q_rp     <= '0;
      r_q_cnt    <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_if_pc[i]  <= '0;
        r_q_pc[i]   <= '0;
        r_q_insn[i] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_if_pc[r_if_wp] <= r_fetch_pc;
        r_if_wp          <= r_if_wp + PW'(1);
      end
      if (w_rsp) begin
        r_if_rp <= r_if_rp + PW'(1);
      end
      r_if_cnt <= w_if_cnt_nxt;

      if (br_taken) begin
        // Everything still outstanding after this edge, including a request accepted now, is wrong-path.
        r_fetch_pc <= {br_target[AWIDTH-1:2], 2'b00};
        r_drop_cnt <= w_if_cnt_nxt;
        r_q_cnt    <= '0;
        r_q_wp     <= '0;
        r_q_rp     <= '0;
      end else begin
        if (w_acc) begin
          r_fetch_pc <= r_fetch_pc + AWIDTH'(4);
        end
        if (w_rsp && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_keep) begin
          r_q_pc[r_q_wp]   <= r_if_pc[r_if_rp];
          r_q_insn[r_q_wp] <= imem.imem_rsp_data;
          r_q_wp           <= r_q_wp + PW'(1);
        end
        if (w_pop) begin
          r_q_rp <= r_q_rp + PW'(1);
        end
        r_q_cnt <= r_q_cnt + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory model plus a reference model of the
// presented instruction stream, compared every cycle by a separate monitor.
module tb_fetch_unit;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_if = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_insn;

  fetch_unit_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  fetch_unit #(.AWIDTH(AW), .DWIDTH(DW), .RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_if  (stall_if),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem      (bus.master),
    .f_valid   (f_valid),
    .f_pc      (f_pc),
    .f_insn    (f_insn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  int          b_cnt;
  logic [31:0] model_pc;
  int          cyc;
  int          last_due;
  int          consumed;
  bit          mon_en;
  int          checks;
  int          failures;

  int          rdy_pct, lmin, lmax, stall_pct, br_pct, bad_pct;
  bit          force_stall, force_br;
  logic [31:0] force_tgt;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the reference model is advanced for the coming edge.
  task automatic cycle();
    bit          rv, rdy, stl, br, rsp;
    logic [31:0] ra, tgt, data;
    bit          consume;
    pend_t       p;
    int          lat, due;
    @(negedge clk);
    rv  = bus.imem_req_valid;
    ra  = bus.imem_req_addr;
    rdy = ($urandom_range(99) < rdy_pct);
    stl = force_stall || ($urandom_range(99) < stall_pct);
    br  = force_br || ($urandom_range(99) < br_pct);
    tgt = force_br ? force_tgt : (RPC | ($urandom & 32'h0000_0FFF));
    rsp = 1'b0;
    data = $urandom;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rsp  = 1'b1;
      data = mem_word(pend_q[0].addr);
    end else if (pend_q.size() == 0 && $urandom_range(99) < bad_pct) begin
      rsp = 1'b1;
    end
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = data;
    stall_if  = stl;
    br_taken  = br;
    br_target = tgt;

    consume = (b_cnt > 0) && !stl && !br;
    if (rsp && pend_q.size() > 0) begin
      p = pend_q.pop_front();
      if (p.live && !br) b_cnt++;
    end
    if (consume) begin
      void'(exp_q.pop_front());
      b_cnt--;
      consumed++;
    end
    if (rv && rdy) begin
      lat = $urandom_range(lmax, lmin);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{addr: ra, due: due, live: 1'b1});
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (br) begin
      b_cnt = 0;
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].live = 1'b0;
      model_pc = {tgt[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    stall_if = 1'b0;
    br_taken = 1'b0;
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'(1));
    chk("rst_req_addr",  64'(bus.imem_req_addr), 64'(RPC));
    chk("rst_f_valid",   64'(f_valid), 64'(0));
    chk("rst_f_pc",      64'(f_pc), 64'(0));
    chk("rst_f_insn",    64'(f_insn), 64'(0));
    pend_q.delete();
    exp_q.delete();
    b_cnt = 0;
    model_pc = RPC;
    last_due = cyc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares DUT outputs against the reference model just after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rst_n) begin
        chk("req_valid", 64'(bus.imem_req_valid), 64'((pend_q.size() + b_cnt) < QD));
        if (bus.imem_req_valid) chk("req_addr", 64'(bus.imem_req_addr), 64'(model_pc));
        chk("f_valid", 64'(f_valid), 64'(b_cnt != 0));
        if (b_cnt > 0 && exp_q.size() > 0) begin
          chk("f_pc",   64'(f_pc),   64'(exp_q[0][63:32]));
          chk("f_insn", 64'(f_insn), 64'(exp_q[0][31:0]));
        end
      end
    end
  end

  initial begin
    int start, budget;
    checks = 0; failures = 0; cyc = 0; consumed = 0; mon_en = 1'b0;
    force_stall = 1'b0; force_br = 1'b0; force_tgt = '0;
    rdy_pct = 100; lmin = 1; lmax = 1; stall_pct = 0; br_pct = 0; bad_pct = 0;
    do_reset();

    run(12);
    force_stall = 1'b1; run(5); force_stall = 1'b0;
    run(6);

    lmin = 3; lmax = 3;
    run(2);
    force_br = 1'b1; force_tgt = 32'h0100_0103; run(1); force_br = 1'b0;
    run(14);

    budget = 0;
    while (b_cnt == 0 && budget < 20) begin cycle(); budget++; end
    chk("bs_setup_valid", 64'(b_cnt != 0), 64'(1));
    force_stall = 1'b1; force_br = 1'b1; force_tgt = 32'h0100_0400;
    run(1);
    force_stall = 1'b0; force_br = 1'b0;
    run(10);

    rdy_pct = 60; lmin = 1; lmax = 4; stall_pct = 25; br_pct = 4; bad_pct = 5;
    start = consumed; budget = 0;
    while (consumed - start < 200 && budget < 5000) begin cycle(); budget++; end
    chk("random_200_consumed", 64'(consumed - start >= 200), 64'(1));

    rdy_pct = 100; lmin = 4; lmax = 4; stall_pct = 0; br_pct = 0; bad_pct = 0;
    run(3);
    do_reset();
    lmin = 1; lmax = 1;
    run(10);

    rdy_pct = 70; lmin = 1; lmax = 3; stall_pct = 15; br_pct = 6; bad_pct = 3;
    run(300);

    @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
